// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a keyboard or mouse using the host request-to-send
// sequence: clock inhibit, start bit, 8 data bits (LSB first), odd parity,
// stop bit and device ACK. The open-drain pins are driven through pull-low
// enables.
//
// Ports:
//   clk, rst    system clock; synchronous active-high reset
//   tx_valid    request to send tx_data (taken only while tx_ready=1)
//   tx_data     byte to send
//   tx_ready    idle and able to accept a byte
//   tx_done     one-cycle pulse: byte sent and ACK seen
//   tx_error    one-cycle pulse: timeout or missing ACK
//   busy        transfer in progress; the receiver ignores the bus
//   ps2_clk_in  raw PS/2 clock pin level (asynchronous)
//   ps2_dat_in  raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe  1 = pull clock line low
//   ps2_dat_oe  1 = pull data line low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3000,
    parameter int unsigned TIMEOUT_CYCLES = 600000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StXfer,
        StAck,
        StWaitIdle
    } state_e;

    localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitn_q, bitn_d;
    // {parity, data}; shifted right one bit per device clock fall
    logic [8:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;
    logic timeout;

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign timeout  = (cnt_q == TimeoutLast);

    assign tx_ready   = (state_q == StIdle) & ~done_q & ~error_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign busy       = (state_q != StIdle);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitn_d   = bitn_q;
        frame_d  = frame_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_d  = {~^tx_data, tx_data};
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == InhibitLast) begin
                    dat_oe_d = 1'b1;
                    state_d  = StStart;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStart: begin
                // Release the clock while holding the start bit low
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b1;
                cnt_d    = '0;
                bitn_d   = '0;
                state_d  = StXfer;
            end
            StXfer: begin
                if (fall) begin
                    cnt_d  = '0;
                    bitn_d = bitn_q + 4'd1;
                    if (bitn_q < 4'd9) begin
                        // Data bits then parity; a 1 bit leaves the line released
                        dat_oe_d = ~frame_q[0];
                        frame_d  = frame_q >> 1;
                    end else if (bitn_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                    end else begin
                        dat_oe_d = 1'b0;
                        clk_oe_d = 1'b0;
                        state_d  = StAck;
                    end
                end else if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAck: begin
                if (timeout) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (!dat_sync_q) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StWaitIdle;
                end else begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q && dat_sync_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (fall) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bitn_q     <= '0;
            frame_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            // Idle bus is high; resetting to 1 avoids a false fall after reset
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks the bus and records the line
// levels it sees; expected outcomes are queued at send time and a monitor
// pops and compares on every tx_done/tx_error pulse.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 8;
    localparam int unsigned Timeout = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    // Open-drain bus: either side can pull low
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .busy(busy),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        bit          is_err;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] obs_frame;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          next_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line levels the device should see: stop, parity, data LSB first, start
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic par, input bit is_err,
                            input bit chk);
        exp_t e;
        e.id        = next_id;
        e.is_err    = is_err;
        e.chk_frame = chk;
        e.frame     = mk_frame(d, par);
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string what);
        int i;
        i = 0;
        while (!tx_ready && i < 400) begin
            @(negedge clk);
            i++;
        end
        check(what, tx_ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input bit is_err,
                        input bit chk, input bit push);
        wait_ready("ready_before_send");
        tx_valid = 1'b1;
        tx_data  = d;
        if (push) push_exp(d, par, is_err, chk);
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drop_after_accept", tx_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    // Device: wait for request-to-send, then produce nfalls clock pulses.
    task automatic device_run(input int nfalls, input bit ack, output int unsigned t_last);
        bit seen;
        seen      = 1'b0;
        t_last    = 0;
        obs_frame = '1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_dat_oe) seen = 1'b1;
        end
        check("request_to_send_seen", seen, 1);
        if (!seen) return;
        repeat (5) @(negedge clk);
        obs_frame[0] = ps2_dat_in;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            t_last  = cyc;
            repeat (8) @(negedge clk);
            if (k <= 10) obs_frame[k] = ps2_dat_in;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_dat = 1'b0;
            if (k == 11) dev_dat = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (tx_done || tx_error)) begin
                check("pulse_expected", exp_q.size() != 0, 1);
                check("done_error_exclusive", tx_done && tx_error, 0);
                check("ready_low_in_pulse", tx_ready, 0);
                check("lines_released_in_pulse", {ps2_clk_oe, ps2_dat_oe}, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("outcome_%0d", e.id), tx_error, e.is_err);
                    if (e.chk_frame)
                        check($sformatf("frame_%0d", e.id), obs_frame, e.frame);
                end
                @(negedge clk);
                check("pulse_one_cycle", tx_done | tx_error, 0);
                check("ready_after_pulse", tx_ready, 1);
            end
        end
    end

    // Inhibit and start-bit phase lengths, checked for every transfer
    int inh_run = 0;
    int st_run = 0;
    always @(negedge clk) begin
        if (ps2_clk_oe && !ps2_dat_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            check("inhibit_len", inh_run, Inhibit);
            inh_run = 0;
        end
        if (ps2_clk_oe && ps2_dat_oe) begin
            st_run++;
        end else if (st_run != 0) begin
            check("start_len", st_run, 1);
            st_run = 0;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle limit reached, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int          i;
        int          g;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("reset_pulses", {tx_done, tx_error}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xED: six ones, so odd parity bit is 1
        send(8'hED, 1'b1, 1'b0, 1'b1, 1'b1);
        device_run(11, 1'b1, t);
        wait_ready("ready_after_ed");

        // 0x00: parity 1
        send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        device_run(11, 1'b1, t);
        wait_ready("ready_after_00");

        // 0xF4: five ones, parity 0; device gives no ACK
        send(8'hF4, 1'b0, 1'b1, 1'b1, 1'b1);
        device_run(11, 1'b0, t);
        wait_ready("ready_after_noack");

        // 0xFF: device stops after fall 4; error 100 cycles after the synced fall
        send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        device_run(4, 1'b0, t);
        i = 0;
        while (!tx_error && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("timeout_seen", tx_error, 1);
        check("timeout_latency", cyc - t, Timeout + 3);
        check("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        wait_ready("ready_after_timeout");

        // Reset in the middle of the data phase (bitn=5): no pulse expected
        send(8'hED, 1'b1, 1'b0, 1'b1, 1'b0);
        device_run(5, 1'b0, t);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_done, tx_error}, 0);
        rst = 1'b0;
        repeat (Timeout + 20) @(negedge clk);
        send(8'hED, 1'b1, 1'b0, 1'b1, 1'b1);
        device_run(11, 1'b1, t);
        wait_ready("ready_after_rst_recovery");

        // tx_valid held high with changing data: only the first byte and then
        // the byte present when tx_ready returns are sent (both have parity 1)
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        push_exp(8'hA5, 1'b1, 1'b0, 1'b1);
        fork
            begin
                g = 0;
                @(negedge clk);
                while (!tx_ready && g < 2000) begin
                    tx_data = ~tx_data;
                    @(negedge clk);
                    g++;
                end
                push_exp(tx_data, 1'b1, 1'b0, 1'b1);
            end
            device_run(11, 1'b1, t);
        join
        tx_valid = 1'b0;
        check("busy_with_second_byte", busy, 1);
        device_run(11, 1'b1, t);
        wait_ready("ready_after_held_valid");
        repeat (5) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
